// File: rtl/ps2_key_tracker.sv
// PS/2 multi-key tracker: decodes make/break/E0 sequences into a
// held-key bitmap with press/release pulses and timeout recovery.
module ps2_key_tracker #(
    parameter int unsigned NUM_KEYS = 8,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {
        9'h174, 9'h16B, 9'h172, 9'h175,
        9'h023, 9'h021, 9'h032, 9'h01C
    },
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic [7:0]          keycodeout,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press_tick,
    output logic [NUM_KEYS-1:0] key_release_tick,
    output logic                any_key,
    output logic [8:0]          last_make,
    output logic                seq_error
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic [8:0]          last_q, last_d;
    logic                err_q, err_d;

    logic                mk, bk, ext;
    logic                expire;
    logic [8:0]          code;
    logic [NUM_KEYS-1:0] hit;

    // Inter-byte timeout; only runs while a sequence is partially received.
    if (TIMEOUT_CYCLES > 0) begin : g_to
        localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        // Next count and expiry strobe; a byte arriving on expiry wins.
        always_comb begin
            cnt_d  = cnt_q;
            expire = 1'b0;
            if (rx_done_tick || state_q == IDLE) begin
                cnt_d = '0;
            end else if (cnt_q == LIM) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clk) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end
    end else begin : g_no_to
        assign expire = 1'b0;
    end

    // Sequence FSM: classifies each byte as make, break, prefix or error.
    always_comb begin
        state_d = state_q;
        mk      = 1'b0;
        bk      = 1'b0;
        ext     = 1'b0;
        err_d   = 1'b0;
        if (rx_done_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (keycodeout == PFX_E0)      state_d = EXT;
                    else if (keycodeout == PFX_F0) state_d = BRK;
                    else                           mk = 1'b1;
                end
                EXT: begin
                    if (keycodeout == PFX_F0) begin
                        state_d = EXT_BRK;
                    end else if (keycodeout != PFX_E0) begin
                        mk      = 1'b1;
                        ext     = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (keycodeout == PFX_E0 || keycodeout == PFX_F0)
                        err_d = 1'b1;
                    else
                        bk = 1'b1;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    ext     = 1'b1;
                    if (keycodeout == PFX_E0 || keycodeout == PFX_F0)
                        err_d = 1'b1;
                    else
                        bk = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    assign code = {ext, keycodeout};

    // Table lookup: every entry equal to the full 9-bit code responds.
    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            hit[i] = (KEY_CODES[9*i +: 9] == code);
        end
    end

    // Per-key held state and edge pulses; repeats and stray breaks are no-ops.
    always_comb begin
        keys_d  = keys_q;
        press_d = '0;
        rel_d   = '0;
        last_d  = last_q;
        if (mk) last_d = code;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (mk && hit[i] && !keys_q[i]) begin
                keys_d[i]  = 1'b1;
                press_d[i] = 1'b1;
            end
            if (bk && hit[i] && keys_q[i]) begin
                keys_d[i] = 1'b0;
                rel_d[i]  = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            keys_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign key_state        = keys_q;
    assign key_press_tick   = press_q;
    assign key_release_tick = rel_q;
    assign any_key          = |keys_q;
    assign last_make        = last_q;
    assign seq_error        = err_q;

endmodule
